// File: rtl/calc_pkg.sv
// calc_pkg: opcode codes, FSM state encoding and pending-operator enum
// shared by calc_core and calc_mul_seq.
package calc_pkg;

   localparam logic [2:0] OP_CLEAR = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_ENTER = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b100;
   localparam logic [2:0] OP_MUL   = 3'b101;
   localparam logic [2:0] OP_ADD   = 3'b111;

   typedef enum logic [2:0] {
      S_NUM     = 3'd0,
      S_NUM_ENT = 3'd1,
      S_OP      = 3'd2,
      S_OP_ENT  = 3'd3,
      S_EXEC    = 3'd4
   } calc_state_e;

   typedef enum logic [1:0] {
      PEND_ADD = 2'd0,
      PEND_SUB = 2'd1,
      PEND_MUL = 2'd2
   } pend_op_e;

   function automatic logic is_arith(logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

   function automatic logic is_rsvd(logic [2:0] op);
      return (op == 3'b011) || (op == 3'b110);
   endfunction

   function automatic pend_op_e to_pend(logic [2:0] op);
      if (op == OP_SUB) return PEND_SUB;
      if (op == OP_MUL) return PEND_MUL;
      return PEND_ADD;
   endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: DATA_W-cycle unsigned shift-add multiplier.
// Ports: clk, reset (async active-low), start_i loads a_i/b_i,
// done_o marks the last step, prod_o is the product after that step.
module calc_mul_seq
   import calc_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_i,
   input  logic [ACC_W-1:0]        a_i,
   input  logic [DATA_W-1:0]       b_i,
   output logic                    done_o,
   output logic [ACC_W+DATA_W-1:0] prod_o
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [ACC_W+DATA_W-1:0] p_q, p_d, step;
   logic [ACC_W-1:0]        a_q, a_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    run_q, run_d;
   logic [ACC_W:0]          sum;
   logic                    last;

   // Upper half accumulates the multiplicand, lower half holds the
   // not-yet-consumed multiplier bits; shift right each step.
   assign sum = {1'b0, p_q[ACC_W+DATA_W-1:DATA_W]}
              + (p_q[0] ? {1'b0, a_q} : '0);

   generate
      if (DATA_W > 1) begin : g_wide
         assign step = {sum, p_q[DATA_W-1:1]};
      end else begin : g_one
         assign step = sum;
      end
   endgenerate

   assign last   = (cnt_q == CW'(DATA_W - 1));
   assign done_o = run_q && last;
   assign prod_o = step;

   always_comb begin
      p_d   = p_q;
      a_d   = a_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start_i) begin
         p_d   = {{ACC_W{1'b0}}, b_i};
         a_d   = a_i;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         p_d   = step;
         cnt_d = cnt_q + 1'b1;
         if (last) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_q   <= '0;
         a_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         p_q   <= p_d;
         a_q   <= a_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/calc_core.sv
// calc_core: opcode-driven calculator FSM + accumulator datapath.
// Ports: cmd_valid/cmd_ready handshake, op_code, values in; out_value,
// busy, ovf, err, stage out. Define CALC_SATURATE_EN to clamp results.
module calc_core
   import calc_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        op_code,
   input  logic [DATA_W-1:0] values,
   output logic [ACC_W-1:0]  out_value,
   output logic              busy,
   output logic              ovf,
   output logic              err,
   output logic [2:0]        stage
);

   calc_state_e       state_q, state_d;
   pend_op_e          pend_q, pend_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] operand_q, operand_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;

   logic                    accept, mul_start, mul_done;
   logic [ACC_W+DATA_W-1:0] prod;
   logic [ACC_W:0]          opx, add_w, sub_w;
   logic [ACC_W-1:0]        alu_res, mul_res;
   logic                    alu_hit, mul_hit;

   assign busy      = (state_q == S_EXEC);
   assign cmd_ready = !busy;
   assign accept    = cmd_valid && cmd_ready;
   assign ovf       = ovf_q;
   assign err       = err_q;
   assign stage     = state_q;

   assign opx   = {{(ACC_W-DATA_W+1){1'b0}}, operand_q};
   assign add_w = {1'b0, acc_q} + opx;
   assign sub_w = {1'b0, acc_q} - opx;

   assign out_value = (state_q == S_NUM_ENT) ? opx[ACC_W-1:0] : acc_q;

   calc_mul_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start_i (mul_start),
      .a_i     (acc_q),
      .b_i     (operand_q),
      .done_o  (mul_done),
      .prod_o  (prod)
   );

   // Bit ACC_W of the widened sum/difference is the carry/borrow.
   always_comb begin
      if (pend_q == PEND_SUB) begin
         alu_res = sub_w[ACC_W-1:0];
         alu_hit = sub_w[ACC_W];
      end else begin
         alu_res = add_w[ACC_W-1:0];
         alu_hit = add_w[ACC_W];
      end
      mul_res = prod[ACC_W-1:0];
      mul_hit = |prod[ACC_W+DATA_W-1:ACC_W];
`ifdef CALC_SATURATE_EN
      if (alu_hit) alu_res = (pend_q == PEND_SUB) ? '0 : '1;
      if (mul_hit) mul_res = '1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      ovf_d     = ovf_q;
      err_d     = 1'b0;
      mul_start = 1'b0;
      if (state_q == S_EXEC) begin
         if (mul_done) begin
            acc_d   = mul_res;
            ovf_d   = ovf_q | mul_hit;
            state_d = S_OP;
         end
      end else if (accept) begin
         if (op_code == OP_CLEAR) begin
            acc_d     = '0;
            operand_d = '0;
            pend_d    = PEND_ADD;
            ovf_d     = 1'b0;
            state_d   = S_NUM;
         end else if (is_rsvd(op_code)) begin
            err_d = 1'b1;
         end else begin
            unique case (state_q)
               S_NUM: begin
                  if (op_code == OP_LOAD) begin
                     operand_d = values;
                     state_d   = S_NUM_ENT;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               S_NUM_ENT: begin
                  unique case (1'b1)
                     (op_code == OP_LOAD): operand_d = values;
                     (op_code == OP_ENTER): begin
                        if (pend_q == PEND_MUL) begin
                           mul_start = 1'b1;
                           state_d   = S_EXEC;
                        end else begin
                           acc_d   = alu_res;
                           ovf_d   = ovf_q | alu_hit;
                           state_d = S_OP;
                        end
                     end
                     default: err_d = 1'b1;
                  endcase
               end
               S_OP: begin
                  if (is_arith(op_code)) begin
                     pend_d  = to_pend(op_code);
                     state_d = S_OP_ENT;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               S_OP_ENT: begin
                  unique case (1'b1)
                     is_arith(op_code):     pend_d  = to_pend(op_code);
                     (op_code == OP_ENTER): state_d = S_NUM;
                     default:               err_d   = 1'b1;
                  endcase
               end
               default: state_d = S_NUM;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_NUM;
         pend_q    <= PEND_ADD;
         acc_q     <= '0;
         operand_q <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed self-checking bench for calc_core
// (DATA_W=4, ACC_W=16), wrap or saturate build.
module tb_calc_core;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  op_code;
   logic [3:0]  values;
   logic [15:0] out_value;
   logic        busy;
   logic        ovf;
   logic        err;
   logic [2:0]  stage;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] C_CLR = 3'b000;
   localparam logic [2:0] C_LD  = 3'b001;
   localparam logic [2:0] C_ENT = 3'b010;
   localparam logic [2:0] C_SUB = 3'b100;
   localparam logic [2:0] C_MUL = 3'b101;
   localparam logic [2:0] C_ADD = 3'b111;

`ifdef CALC_SATURATE_EN
   localparam int EXP_SUB = 0;
   localparam int EXP_MOV = 32'hFFFF;
`else
   localparam int EXP_SUB = 32'hFFFE;
   localparam int EXP_MOV = 0;
`endif

   calc_core #(.DATA_W(4), .ACC_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .op_code   (op_code),
      .values    (values),
      .out_value (out_value),
      .busy      (busy),
      .ovf       (ovf),
      .err       (err),
      .stage     (stage)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] op, input int v);
      @(negedge clk);
      cmd_valid = 1'b1;
      op_code   = op;
      values    = 4'(v);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mul_timeout", 32'(busy), 0);
   endtask

   task automatic do_mul(input int v);
      cmd(C_MUL, 0);
      cmd(C_ENT, 0);
      cmd(C_LD, v);
      cmd(C_ENT, 0);
      wait_idle();
   endtask

   initial begin
      int n;
      logic err_seen;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      op_code   = 3'b000;
      values    = 4'd0;
      #23;
      chk("rst_out", 32'(out_value), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_stage", 32'(stage), 0);
      @(negedge clk);
      reset = 1'b1;

      // 2 + 7 + 3
      cmd(C_LD, 2);
      chk("ld2_disp", 32'(out_value), 2);
      chk("ld2_stage", 32'(stage), 1);
      cmd(C_ENT, 0);
      chk("ent_acc2", 32'(out_value), 2);
      chk("ent_stage", 32'(stage), 2);
      cmd(C_ADD, 0);
      cmd(C_ENT, 0);
      cmd(C_LD, 7);
      chk("ld7_disp", 32'(out_value), 7);
      cmd(C_ENT, 0);
      chk("acc9", 32'(out_value), 9);
      cmd(C_ADD, 0);
      cmd(C_ENT, 0);
      cmd(C_LD, 3);
      cmd(C_ENT, 0);
      chk("sum12", 32'(out_value), 12);
      chk("sum_ovf", 32'(ovf), 0);

      // 3 - 5 underflow
      cmd(C_CLR, 0);
      chk("clr_out", 32'(out_value), 0);
      chk("clr_stage", 32'(stage), 0);
      cmd(C_LD, 3);
      cmd(C_ENT, 0);
      cmd(C_SUB, 0);
      cmd(C_ENT, 0);
      cmd(C_LD, 5);
      cmd(C_ENT, 0);
      chk("sub_val", 32'(out_value), EXP_SUB);
      chk("sub_ovf", 32'(ovf), 1);

      // 9 * 7 with CLEAR held during busy
      cmd(C_CLR, 0);
      chk("clr_ovf", 32'(ovf), 0);
      cmd(C_LD, 9);
      cmd(C_ENT, 0);
      cmd(C_MUL, 0);
      cmd(C_ENT, 0);
      cmd(C_LD, 7);
      cmd(C_ENT, 0);
      chk("mul_busy", 32'(busy), 1);
      chk("mul_ready", 32'(cmd_ready), 0);
      chk("mul_stage", 32'(stage), 4);
      cmd_valid = 1'b1;
      op_code   = C_CLR;
      n         = 0;
      err_seen  = 1'b0;
      while (busy && n < 20) begin
         @(posedge clk);
         #1;
         err_seen = err_seen | err;
         n++;
      end
      cmd_valid = 1'b0;
      chk("mul_cycles", n, 4);
      chk("mul_noerr", 32'(err_seen), 0);
      chk("mul_63", 32'(out_value), 63);
      chk("mul_stage_op", 32'(stage), 2);
      chk("mul_ovf", 32'(ovf), 0);

      // 16'h4000 * 8 overflow
      cmd(C_CLR, 0);
      cmd(C_LD, 8);
      cmd(C_ENT, 0);
      do_mul(8);
      do_mul(8);
      do_mul(8);
      do_mul(4);
      chk("acc_4000", 32'(out_value), 32'h4000);
      chk("acc_4000_ovf", 32'(ovf), 0);
      do_mul(8);
      chk("mulovf_val", 32'(out_value), EXP_MOV);
      chk("mulovf_flag", 32'(ovf), 1);

      // illegal LOAD in S_OP
      cmd(C_LD, 5);
      chk("err_ld_op", 32'(err), 1);
      chk("err_ld_stage", 32'(stage), 2);
      chk("err_ld_acc", 32'(out_value), EXP_MOV);
      @(posedge clk);
      #1;
      chk("err_ld_pulse", 32'(err), 0);

      // reserved 011 in S_NUM
      cmd(C_CLR, 0);
      cmd(3'b011, 9);
      chk("err_rsv", 32'(err), 1);
      chk("err_rsv_stage", 32'(stage), 0);
      chk("err_rsv_acc", 32'(out_value), 0);
      @(posedge clk);
      #1;
      chk("err_rsv_pulse", 32'(err), 0);

      // reserved 110 in S_NUM_ENT keeps operand
      cmd(C_LD, 6);
      cmd(3'b110, 9);
      chk("err_110", 32'(err), 1);
      chk("err_110_stage", 32'(stage), 1);
      chk("err_110_opnd", 32'(out_value), 6);

      // reset mid-MUL
      cmd(C_CLR, 0);
      cmd(C_LD, 3);
      cmd(C_ENT, 0);
      cmd(C_MUL, 0);
      cmd(C_ENT, 0);
      cmd(C_LD, 5);
      cmd(C_ENT, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("rmid_busy", 32'(busy), 0);
      chk("rmid_ready", 32'(cmd_ready), 1);
      chk("rmid_out", 32'(out_value), 0);
      chk("rmid_stage", 32'(stage), 0);
      chk("rmid_ovf", 32'(ovf), 0);
      @(negedge clk);
      reset = 1'b1;
      cmd(C_CLR, 0);
      cmd(C_LD, 2);
      cmd(C_ENT, 0);
      chk("post_rst", 32'(out_value), 2);
      chk("post_rst_stage", 32'(stage), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
